// File: rtl/fc_mac_engine_if.sv
// Bundles the fc_mac_engine vector input handshake and score output stream.
// The master side is the producer/consumer; the slave side is the engine.
interface fc_mac_engine_if #(
  parameter int unsigned IN_VEC  = 48,
  parameter int unsigned IN_BW   = 8,
  parameter int unsigned OUT_NUM = 10,
  parameter int unsigned ACC_BW  = 24
) ();

  localparam int unsigned IDX_W = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1;

  logic                     i_in_valid;
  logic                     o_in_ready;
  logic [IN_VEC*IN_BW-1:0]  i_in_vec;
  logic                     o_ot_valid;
  logic [ACC_BW-1:0]        o_ot_data;
  logic [IDX_W-1:0]         o_ot_idx;
  logic                     o_ot_last;
  logic                     o_busy;

  modport master (
    output i_in_valid, i_in_vec,
    input  o_in_ready, o_ot_valid, o_ot_data, o_ot_idx, o_ot_last, o_busy
  );

  modport slave (
    input  i_in_valid, i_in_vec,
    output o_in_ready, o_ot_valid, o_ot_data, o_ot_idx, o_ot_last, o_busy
  );

endinterface

// File: rtl/fc_mac_engine.sv
// Fully-connected classifier stage: serial MAC of one pooled feature vector
// against a fixed weight/bias ROM, one signed score streamed per neuron.
// ROM images are supplied as packed elaboration-time parameters:
//   W_INIT entry a = n*IN_VEC + k at bits [a*W_BW +: W_BW]
//   B_INIT entry n at bits [n*B_BW +: B_BW]
// Optional feature: define FC_RELU_EN to clamp negative scores to zero.
module fc_mac_engine #(
  parameter int unsigned IN_VEC  = 48,
  parameter int unsigned OUT_NUM = 10,
  parameter int unsigned IN_BW   = 8,
  parameter int unsigned W_BW    = 8,
  parameter int unsigned B_BW    = 16,
  parameter int unsigned ACC_BW  = 24,
  parameter logic [OUT_NUM*IN_VEC*W_BW-1:0] W_INIT = {(OUT_NUM*IN_VEC){W_BW'(1)}},
  parameter logic [OUT_NUM*B_BW-1:0]        B_INIT = '0
) (
  input logic            clk,
  input logic            reset,
  fc_mac_engine_if.slave bus
);

  localparam int unsigned IDX_W = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1;
  localparam int unsigned K_W   = (IN_VEC > 1) ? $clog2(IN_VEC) : 1;
  localparam int unsigned P_W   = IN_BW + W_BW;
  localparam int unsigned WA_W  = $clog2(OUT_NUM * IN_VEC);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_BIAS = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          n_q, n_d;
  logic [K_W-1:0]            k_q, k_d;
  logic signed [ACC_BW-1:0]  acc_q, acc_d;
  logic signed [IN_BW-1:0]   x_q [IN_VEC];

  logic                      ready_q, ready_d;
  logic                      busy_q, busy_d;
  logic                      ot_valid_q, ot_valid_d;
  logic [ACC_BW-1:0]         ot_data_q, ot_data_d;
  logic [IDX_W-1:0]          ot_idx_q, ot_idx_d;
  logic                      ot_last_q, ot_last_d;

  logic                      accept;
  logic [WA_W-1:0]           w_addr;
  logic signed [W_BW-1:0]    w_cur;
  logic signed [B_BW-1:0]    b_cur;
  logic signed [P_W-1:0]     prod;
  logic signed [ACC_BW-1:0]  sum;
  logic                      last_n;

  // ROM lookup and arithmetic for the current neuron/feature
  always_comb begin : datapath
    w_addr = WA_W'(n_q) * WA_W'(IN_VEC) + WA_W'(k_q);
    w_cur  = W_INIT[w_addr*W_BW +: W_BW];
    b_cur  = B_INIT[n_q*B_BW +: B_BW];
    prod   = P_W'(x_q[k_q]) * P_W'(w_cur);
    sum    = acc_q + ACC_BW'(b_cur);
    last_n = (n_q == IDX_W'(OUT_NUM - 1));
  end

  // Next-state and next-output logic
  always_comb begin : next_logic
    state_d    = state_q;
    n_d        = n_q;
    k_d        = k_q;
    acc_d      = acc_q;
    ready_d    = 1'b0;
    ot_valid_d = 1'b0;
    ot_data_d  = ot_data_q;
    ot_idx_d   = ot_idx_q;
    ot_last_d  = ot_last_q;
    accept     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (bus.i_in_valid && ready_q) begin
          accept  = 1'b1;
          ready_d = 1'b0;
          acc_d   = '0;
          n_d     = '0;
          k_d     = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + ACC_BW'(prod);
        if (k_q == K_W'(IN_VEC - 1)) begin
          k_d     = '0;
          state_d = S_BIAS;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      S_BIAS: begin
        ot_valid_d = 1'b1;
`ifdef FC_RELU_EN
        ot_data_d  = sum[ACC_BW-1] ? '0 : sum;
`else
        ot_data_d  = sum;
`endif
        ot_idx_d   = n_q;
        ot_last_d  = last_n;
        acc_d      = '0;
        k_d        = '0;
        if (last_n) begin
          state_d = S_IDLE;
        end else begin
          n_d     = n_q + IDX_W'(1);
          state_d = S_MAC;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, counters, accumulator and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      ot_valid_q <= 1'b0;
      ot_data_q  <= '0;
      ot_idx_q   <= '0;
      ot_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      ot_valid_q <= ot_valid_d;
      ot_data_q  <= ot_data_d;
      ot_idx_q   <= ot_idx_d;
      ot_last_q  <= ot_last_d;
    end
  end

  // Feature vector capture on accept; held for the whole computation
  always_ff @(posedge clk) begin
    if (accept && !reset) begin
      for (int k = 0; k < IN_VEC; k++) begin
        x_q[k] <= bus.i_in_vec[k*IN_BW +: IN_BW];
      end
    end
  end

  assign bus.o_in_ready = ready_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_ot_valid = ot_valid_q;
  assign bus.o_ot_data  = ot_data_q;
  assign bus.o_ot_idx   = ot_idx_q;
  assign bus.o_ot_last  = ot_last_q;

endmodule

// File: tb/tb_fc_mac_engine.sv
// Bench for fc_mac_engine: two engines (all-ones ROM and mixed ROM) driven
// with directed and random vectors; a scoreboard queue per engine is filled
// from an arithmetic reference model and drained by a strobe monitor.
module tb_fc_mac_engine;

  localparam int unsigned IN_VEC  = 48;
  localparam int unsigned OUT_NUM = 10;
  localparam int unsigned IN_BW   = 8;
  localparam int unsigned W_BW    = 8;
  localparam int unsigned B_BW    = 16;
  localparam int unsigned ACC_BW  = 24;
  localparam int unsigned IDX_W   = $clog2(OUT_NUM);
  localparam int unsigned NB      = IN_VEC + 1;
  localparam int unsigned WTOT    = OUT_NUM * IN_VEC * W_BW;
  localparam int unsigned BTOT    = OUT_NUM * B_BW;
  localparam int unsigned GUARD   = 2000;

  typedef logic [IN_VEC*IN_BW-1:0] vec_t;
  typedef struct {
    int unsigned       idx;
    logic [ACC_BW-1:0] data;
    logic              last;
    int unsigned       due;
  } exp_t;

  // Mixed ROM: neuron 0 weights all 127, remaining neurons pseudo-random
  function automatic logic [WTOT-1:0] mk_w();
    logic [WTOT-1:0] r;
    logic [31:0]     s;
    r = '0;
    s = 32'd12345;
    for (int a = 0; a < OUT_NUM * IN_VEC; a++) begin
      s = s * 32'd1103515245 + 32'd12345;
      if (a < IN_VEC) r[a*W_BW +: W_BW] = 8'd127;
      else            r[a*W_BW +: W_BW] = s[23:16];
    end
    return r;
  endfunction

  // Mixed biases: bias 0 is -5, remaining pseudo-random
  function automatic logic [BTOT-1:0] mk_b();
    logic [BTOT-1:0] r;
    logic [31:0]     s;
    r = '0;
    s = 32'd777;
    for (int n = 0; n < OUT_NUM; n++) begin
      s = s * 32'd1103515245 + 32'd12345;
      if (n == 0) r[n*B_BW +: B_BW] = 16'hFFFB;
      else        r[n*B_BW +: B_BW] = s[31:16];
    end
    return r;
  endfunction

  localparam logic [WTOT-1:0] ONE_W = {(OUT_NUM*IN_VEC){8'h01}};
  localparam logic [BTOT-1:0] ONE_B = '0;
  localparam logic [WTOT-1:0] MIX_W = mk_w();
  localparam logic [BTOT-1:0] MIX_B = mk_b();

  logic        clk = 1'b0;
  logic        rst_a;
  logic        rst_b;
  int unsigned cyc = 0;
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  exp_t        q_a[$];
  exp_t        q_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fc_mac_engine_if #(.IN_VEC(IN_VEC), .IN_BW(IN_BW), .OUT_NUM(OUT_NUM), .ACC_BW(ACC_BW)) if_a ();
  fc_mac_engine_if #(.IN_VEC(IN_VEC), .IN_BW(IN_BW), .OUT_NUM(OUT_NUM), .ACC_BW(ACC_BW)) if_b ();

  fc_mac_engine #(
    .IN_VEC(IN_VEC), .OUT_NUM(OUT_NUM), .IN_BW(IN_BW), .W_BW(W_BW),
    .B_BW(B_BW), .ACC_BW(ACC_BW), .W_INIT(ONE_W), .B_INIT(ONE_B)
  ) u_ones (.clk(clk), .reset(rst_a), .bus(if_a));

  fc_mac_engine #(
    .IN_VEC(IN_VEC), .OUT_NUM(OUT_NUM), .IN_BW(IN_BW), .W_BW(W_BW),
    .B_BW(B_BW), .ACC_BW(ACC_BW), .W_INIT(MIX_W), .B_INIT(MIX_B)
  ) u_mix (.clk(clk), .reset(rst_b), .bus(if_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Reference score: plain integer dot product plus bias, wrapped to ACC_BW
  function automatic logic [ACC_BW-1:0] ref_score(input int which, input vec_t v, input int n);
    int                     sum;
    logic signed [IN_BW-1:0] xv;
    logic signed [W_BW-1:0]  wv;
    logic signed [B_BW-1:0]  bv;
    logic [WTOT-1:0]         wt;
    logic [BTOT-1:0]         bt;
    logic [ACC_BW-1:0]       r;
    wt  = (which == 0) ? ONE_W : MIX_W;
    bt  = (which == 0) ? ONE_B : MIX_B;
    sum = 0;
    for (int k = 0; k < IN_VEC; k++) begin
      xv  = v[k*IN_BW +: IN_BW];
      wv  = wt[(n*IN_VEC + k)*W_BW +: W_BW];
      sum = sum + int'(xv) * int'(wv);
    end
    bv  = bt[n*B_BW +: B_BW];
    sum = sum + int'(bv);
    r   = sum[ACC_BW-1:0];
`ifdef FC_RELU_EN
    if (r[ACC_BW-1]) r = '0;
`endif
    return r;
  endfunction

  function automatic vec_t rnd_vec();
    vec_t v;
    for (int k = 0; k < IN_VEC; k++) v[k*IN_BW +: IN_BW] = IN_BW'($urandom);
    return v;
  endfunction

  function automatic vec_t const_vec(input logic [IN_BW-1:0] b);
    vec_t v;
    for (int k = 0; k < IN_VEC; k++) v[k*IN_BW +: IN_BW] = b;
    return v;
  endfunction

  function automatic logic rdy(input int which);
    return (which == 0) ? if_a.o_in_ready : if_b.o_in_ready;
  endfunction

  function automatic logic bsy(input int which);
    return (which == 0) ? if_a.o_busy : if_b.o_busy;
  endfunction

  function automatic int unsigned qsize(input int which);
    return (which == 0) ? q_a.size() : q_b.size();
  endfunction

  task automatic drive(input int which, input logic valid, input vec_t d);
    if (which == 0) begin
      if_a.i_in_valid = valid;
      if_a.i_in_vec   = d;
    end else begin
      if_b.i_in_valid = valid;
      if_b.i_in_vec   = d;
    end
  endtask

  // Queue the full expected strobe sequence for a vector accepted at edge t
  task automatic expect_vec(input int which, input vec_t v, input int unsigned t);
    exp_t e;
    for (int n = 0; n < OUT_NUM; n++) begin
      e.idx  = n;
      e.data = ref_score(which, v, n);
      e.last = (n == OUT_NUM - 1);
      e.due  = t + NB * (n + 1);
      if (which == 0) q_a.push_back(e);
      else            q_b.push_back(e);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge
  task automatic send(input int which, input vec_t v, output int unsigned t);
    int unsigned g;
    g = 0;
    while (rdy(which) !== 1'b1 && g < GUARD) begin
      @(negedge clk);
      g++;
    end
    if (g >= GUARD) fail_now($sformatf("dut%0d_ready_timeout", which));
    drive(which, 1'b1, v);
    @(posedge clk);
    @(negedge clk);
    t = cyc;
    drive(which, 1'b0, rnd_vec());
    chk($sformatf("dut%0d_ready_low_after_accept", which), 32'(rdy(which)), 32'd0);
    chk($sformatf("dut%0d_busy_after_accept", which), 32'(bsy(which)), 32'd1);
    expect_vec(which, v, t);
  endtask

  task automatic wait_done(input int which);
    int unsigned g;
    g = 0;
    while (qsize(which) != 0 && g < GUARD) begin
      @(negedge clk);
      g++;
    end
    if (g >= GUARD) fail_now($sformatf("dut%0d_result_timeout", which));
  endtask

  task automatic check_strobe(input int which, input logic [ACC_BW-1:0] d,
                              input logic [IDX_W-1:0] i, input logic l);
    exp_t e;
    if (qsize(which) == 0) begin
      fail_now($sformatf("dut%0d_unexpected_strobe idx=%0d data=0x%0h", which, i, d));
      return;
    end
    if (which == 0) e = q_a.pop_front();
    else            e = q_b.pop_front();
    chk($sformatf("dut%0d_n%0d_data", which, e.idx), 32'(d), 32'(e.data));
    chk($sformatf("dut%0d_n%0d_idx", which, e.idx), 32'(i), e.idx);
    chk($sformatf("dut%0d_n%0d_last", which, e.idx), 32'(l), 32'(e.last));
    chk($sformatf("dut%0d_n%0d_time", which, e.idx), cyc, e.due);
  endtask

  // Monitor: every strobe is matched against the head of its scoreboard
  always @(negedge clk) begin
    if (if_a.o_ot_valid === 1'b1) check_strobe(0, if_a.o_ot_data, if_a.o_ot_idx, if_a.o_ot_last);
    if (if_b.o_ot_valid === 1'b1) check_strobe(1, if_b.o_ot_data, if_b.o_ot_idx, if_b.o_ot_last);
  end

  initial begin
    #600000;
    $display("FAIL watchdog_timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t;
    int unsigned t2;
    int unsigned lst;
    int unsigned cnt;
    int unsigned g;
    vec_t        v1;
    vec_t        v2;

    // Reset held with valid asserted: must stay idle
    rst_a = 1'b1;
    rst_b = 1'b1;
    drive(0, 1'b1, rnd_vec());
    drive(1, 1'b1, rnd_vec());
    repeat (3) @(negedge clk);
    chk("rst_a_ready", 32'(if_a.o_in_ready), 32'd1);
    chk("rst_a_valid", 32'(if_a.o_ot_valid), 32'd0);
    chk("rst_a_data",  32'(if_a.o_ot_data),  32'd0);
    chk("rst_a_idx",   32'(if_a.o_ot_idx),   32'd0);
    chk("rst_a_last",  32'(if_a.o_ot_last),  32'd0);
    chk("rst_a_busy",  32'(if_a.o_busy),     32'd0);
    chk("rst_b_ready", 32'(if_b.o_in_ready), 32'd1);
    chk("rst_b_valid", 32'(if_b.o_ot_valid), 32'd0);
    chk("rst_b_busy",  32'(if_b.o_busy),     32'd0);
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);

    // All-ones ROM, x=2: every score 96, strobes 49 cycles apart
    send(0, const_vec(8'd2), t);
    cnt = 0;
    while (if_a.o_busy === 1'b1 && cnt < GUARD) begin
      cnt++;
      @(negedge clk);
    end
    chk("ones_busy_cycles", cnt, OUT_NUM * NB);
    chk("ones_ready_at_last", 32'(if_a.o_in_ready), 32'd0);
    @(negedge clk);
    chk("ones_ready_after_last", 32'(if_a.o_in_ready), 32'd1);
    wait_done(0);

    // Random vector on the all-ones engine
    send(0, rnd_vec(), t);
    wait_done(0);

    // x=-128, neuron 0 weights 127 and bias -5
    send(1, const_vec(8'h80), t);
`ifdef FC_RELU_EN
    q_b[0].data = '0;
`else
    q_b[0].data = ACC_BW'(-780293);
`endif
    wait_done(1);

    // Random vectors on the mixed engine
    for (int r = 0; r < 3; r++) begin
      send(1, rnd_vec(), t);
      wait_done(1);
    end

    // Busy-ignore: a second vector mid-computation must be dropped
    send(1, rnd_vec(), t);
    repeat (10) @(negedge clk);
    drive(1, 1'b1, rnd_vec());
    chk("ignore_ready_low", 32'(if_b.o_in_ready), 32'd0);
    @(negedge clk);
    drive(1, 1'b0, '0);
    wait_done(1);
    repeat (120) @(negedge clk);
    chk("ignore_idle_ready", 32'(if_b.o_in_ready), 32'd1);

    // Back-to-back: next vector presented in first idle cycle after last strobe
    v1 = rnd_vec();
    v2 = rnd_vec();
    send(1, v1, t);
    g = 0;
    while (!(if_b.o_ot_valid === 1'b1 && if_b.o_ot_last === 1'b1) && g < GUARD) begin
      @(negedge clk);
      g++;
    end
    if (g >= GUARD) fail_now("b2b_last_timeout");
    lst = cyc;
    @(negedge clk);
    chk("b2b_ready_first_idle", 32'(if_b.o_in_ready), 32'd1);
    drive(1, 1'b1, v2);
    @(posedge clk);
    @(negedge clk);
    t2 = cyc;
    drive(1, 1'b0, '0);
    chk("b2b_accept_edge", t2, lst + 2);
    chk("b2b_ready_low", 32'(if_b.o_in_ready), 32'd0);
    expect_vec(1, v2, t2);
    wait_done(1);

    // Mid-operation reset after neuron 3's strobe
    send(1, rnd_vec(), t);
    g = 0;
    while (!(if_b.o_ot_valid === 1'b1 && if_b.o_ot_idx === IDX_W'(3)) && g < GUARD) begin
      @(negedge clk);
      g++;
    end
    if (g >= GUARD) fail_now("midrst_n3_timeout");
    @(negedge clk);
    rst_b = 1'b1;
    q_b.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_ready", 32'(if_b.o_in_ready), 32'd1);
    chk("midrst_busy",  32'(if_b.o_busy),     32'd0);
    chk("midrst_valid", 32'(if_b.o_ot_valid), 32'd0);
    chk("midrst_data",  32'(if_b.o_ot_data),  32'd0);
    chk("midrst_idx",   32'(if_b.o_ot_idx),   32'd0);
    rst_b = 1'b0;
    repeat (120) @(negedge clk);
    send(1, rnd_vec(), t);
    wait_done(1);

    repeat (5) @(negedge clk);
    chk("final_queue_a_empty", q_a.size(), 32'd0);
    chk("final_queue_b_empty", q_b.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
